axi_ppm_rx_nch: RTL
===================

// Module: axi_ppm_rx_nch
// PURPOSE
//  Parametrised AXI4-Lite slave PPM receiver; successor to the fixed 4-register ppm_32R block.
//  Decodes one PPM pulse train into NUM_CH channel pulse widths, counted in ACLK cycles.
//  Commits each complete frame atomically and exposes it, with status and a frame counter, as registers.
//  Sits in the UAV block design under the PS AXI master; drives an optional frame IRQ.
// PARAMETERS
//  NUM_CH        8       channels per PPM frame (1..16)
//  CNT_W         20      width of the gap counter and CH registers (<=32)
//  SYNC_DEFAULT  5000    reset value of SYNC_MIN: minimum gap, in cycles, treated as frame sync
//  PPM_INVERT    0       1: invert PPM_IN before edge detection
//  ADDR_W        7       AXI address width; must hold 0x10+4*NUM_CH
// PORTS
//  ACLK          in   1      system clock; all logic is on the rising edge
//  ARESETN       in   1      asynchronous active-low reset
//  PPM_IN        in   1      raw PPM input, asynchronous to ACLK
//  S_AXI_AW*     -    -      AWADDR[ADDR_W], AWPROT[3], AWVALID in; AWREADY out
//  S_AXI_W*      -    -      WDATA[32], WSTRB[4], WVALID in; WREADY out
//  S_AXI_B*      -    -      BRESP[2], BVALID out; BREADY in
//  S_AXI_AR*     -    -      ARADDR[ADDR_W], ARPROT[3], ARVALID in; ARREADY out
//  S_AXI_R*      -    -      RDATA[32], RRESP[2], RVALID out; RREADY in
//  IRQ           out  1      level interrupt: STATUS.frame_valid & CTRL.irq_en
// BEHAVIOUR
//  Reset: all AXI READY/VALID outputs 0; BRESP, RRESP, RDATA = 0; IRQ = 0.
//   CTRL = 0; SYNC_MIN = SYNC_DEFAULT; STATUS, FRAME_CNT, CH[i] = 0; FSM = IDLE.
//  Register map (word-aligned; ARADDR/AWADDR[1:0] ignored):
//   0x00 CTRL RW: [0] enable, [1] clr_status (write-1 pulse, reads 0), [2] irq_en
//   0x04 STATUS RO: [0] frame_valid (sticky), [1] frame_err (sticky), [15:8] chans seen in last frame
//   0x08 FRAME_CNT RO: 32-bit count of committed frames; wraps 0xFFFFFFFF -> 0
//   0x0C SYNC_MIN RW: [CNT_W-1:0]
//   0x10+4*i CH[i] RO: [CNT_W-1:0] width of channel i; upper bits read 0
//  WSTRB is honoured per byte on RW registers. Writes to RO registers are ignored and return OKAY.
//  Any address >= 0x10+4*NUM_CH returns SLVERR: reads return 0, writes have no effect.
//  AXI write: AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & !BVALID.
//   Register updates at that edge; BVALID rises on the next cycle and holds until BREADY.
//  AXI read: ARREADY pulses for one cycle when ARVALID & !RVALID.
//   RDATA/RVALID are registered the next cycle and held stable until RREADY.
//  Read and write channels operate independently; both may handshake in the same cycle.
//  Input path: 2-FF synchroniser, optional invert, then a rising-edge detect (1-cycle pulse, `edge`).
//  Gap counter: loads 1 on `edge`, otherwise increments; saturates at 2^CNT_W-1.
//   At an edge the measured gap is the counter value before the load.
//   The latency from PPM_IN to `edge` is 3 cycles, identical on every edge, so widths are exact.
//  FSM:
//   IDLE:      entered while CTRL.enable=0. Counter held at 0; CH, STATUS, FRAME_CNT retained.
//   WAIT_SYNC: on edge with gap >= SYNC_MIN -> CAPTURE, ch_idx = 0.
//   CAPTURE:   on edge with gap <  SYNC_MIN:
//               if ch_idx < NUM_CH: shadow[ch_idx] = gap, ch_idx++.
//               else: set frame_err, -> WAIT_SYNC (too many channels).
//              on edge with gap >= SYNC_MIN:
//               if ch_idx == NUM_CH: commit all shadow -> CH[] in one cycle,
//                FRAME_CNT++, frame_valid = 1.
//               else: frame_err = 1, no commit.
//               STATUS[15:8] = ch_idx in both cases; stay in CAPTURE with ch_idx = 0.
//  Clearing enable in any state -> IDLE next cycle; the partial frame is discarded.
//  Setting enable from IDLE -> WAIT_SYNC.
//  clr_status clears frame_valid and frame_err.
//   If a commit or error happens in the same cycle, the set wins.
//  A CH read in the commit cycle returns the pre-commit value; the next read returns the new value.
// TESTING
//  T1 After reset: read 0x00..0x0C -> 0, 0, 0, 5000 (SYNC_DEFAULT); IRQ = 0; RRESP = OKAY.
//  T2 enable=1, SYNC_MIN=100; sync gap 200, then 8 gaps 10,20,..,80, then sync gap 200:
//     CH[0..7] = 10..80, FRAME_CNT = 1, STATUS = 0x0801.
//  T3 Frame with only 5 short gaps before sync -> STATUS = 0x0502, CH[] unchanged, FRAME_CNT unchanged.
//  T4 Write 0x40 (NUM_CH=8) -> BRESP = SLVERR; read 0x40 -> RDATA = 0, RRESP = SLVERR;
//     write 0x10 -> OKAY and CH[0] unchanged.
//  T5 irq_en=1 and T2 frame: IRQ rises the cycle after commit; write CTRL = 0x7 (clr) -> IRQ falls.
//  T6 ARESETN low mid-frame, then deassert: all registers at reset values;
//     no stale commit after re-enable. BREADY held low for 10 cycles: BVALID and BRESP held stable.

Source files
------------

// File: rtl/axi_ppm_rx_nch.sv
`timescale 1ns/1ps
// AXI4-Lite slave PPM receiver: measures NUM_CH channel widths per frame in ACLK cycles
// and commits each complete frame atomically into readable CH registers.
module axi_ppm_rx_nch #(
    parameter int NUM_CH       = 8,
    parameter int CNT_W        = 20,
    parameter int SYNC_DEFAULT = 5000,
    parameter int PPM_INVERT   = 0,
    parameter int ADDR_W       = 7
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              PPM_IN,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic [2:0]        S_AXI_AWPROT,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic [2:0]        S_AXI_ARPROT,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    output logic              IRQ
);

    localparam int               IDX_W    = $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] SYNC_RST = CNT_W'(SYNC_DEFAULT);
    localparam int unsigned      N_WORDS  = 4 + NUM_CH;
    localparam logic [1:0]       RESP_OK  = 2'b00;
    localparam logic [1:0]       RESP_ERR = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SYNC, ST_CAPTURE} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         ch_idx_q, ch_idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     sync1_q, sync2_q, prev_q, edge_q;
    logic                     ppm_s;
    logic [CNT_W-1:0]         shadow_q [NUM_CH];
    logic [CNT_W-1:0]         ch_q     [NUM_CH];
    logic                     ctrl_en_q, ctrl_irq_q;
    logic [CNT_W-1:0]         sync_min_q, sync_min_d;
    logic                     frame_valid_q, frame_valid_d;
    logic                     frame_err_q, frame_err_d;
    logic [7:0]               chans_q;
    logic [31:0]              frame_cnt_q;
    logic                     rdy_en_q;
    logic                     bvalid_q, rvalid_q;
    logic [1:0]               bresp_q, rresp_q;
    logic [31:0]              rdata_q;

    logic                     gap_is_sync, shadow_we, commit, frame_bad, chans_we;
    logic                     aw_hs, ar_hs, aw_ok, ar_ok, clr_status;
    logic [ADDR_W-3:0]        aw_word, ar_word;
    logic [31:0]              rd_data;
    logic [1:0]               rd_resp;
    logic                     unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         S_AXI_WDATA, S_AXI_WSTRB};

    // ---------------- input path ----------------
    assign ppm_s = (PPM_INVERT != 0) ? ~sync2_q : sync2_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= (PPM_INVERT != 0);
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= PPM_IN;
            sync2_q <= sync1_q;
            prev_q  <= ppm_s;
            edge_q  <= ppm_s & ~prev_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (edge_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // ---------------- frame FSM ----------------
    assign gap_is_sync = (cnt_q >= sync_min_q);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= ST_IDLE;
            ch_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_idx_d  = ch_idx_q;
        shadow_we = 1'b0;
        commit    = 1'b0;
        frame_bad = 1'b0;
        chans_we  = 1'b0;
        if (!ctrl_en_q) begin
            state_d  = ST_IDLE;
            ch_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_WAIT_SYNC;
                    ch_idx_d = '0;
                end
                ST_WAIT_SYNC: begin
                    if (edge_q && gap_is_sync) begin
                        state_d  = ST_CAPTURE;
                        ch_idx_d = '0;
                    end
                end
                ST_CAPTURE: begin
                    if (edge_q) begin
                        if (!gap_is_sync) begin
                            if (ch_idx_q < IDX_W'(NUM_CH)) begin
                                shadow_we = 1'b1;
                                ch_idx_d  = ch_idx_q + 1'b1;
                            end else begin
                                frame_bad = 1'b1;
                                state_d   = ST_WAIT_SYNC;
                                ch_idx_d  = '0;
                            end
                        end else begin
                            // sync closes the current frame and opens the next one
                            chans_we = 1'b1;
                            if (ch_idx_q == IDX_W'(NUM_CH)) begin
                                commit = 1'b1;
                            end else begin
                                frame_bad = 1'b1;
                            end
                            ch_idx_d = '0;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    ch_idx_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                ch_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (shadow_we && (ch_idx_q == IDX_W'(i))) begin
                    shadow_q[i] <= cnt_q;
                end
                if (commit) begin
                    ch_q[i] <= shadow_q[i];
                end
            end
        end
    end

    // ---------------- register file ----------------
    assign aw_word    = S_AXI_AWADDR[ADDR_W-1:2];
    assign ar_word    = S_AXI_ARADDR[ADDR_W-1:2];
    assign aw_ok      = (32'(aw_word) < N_WORDS);
    assign ar_ok      = (32'(ar_word) < N_WORDS);
    assign aw_hs      = rdy_en_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    assign ar_hs      = rdy_en_q & S_AXI_ARVALID & ~rvalid_q;
    assign clr_status = aw_hs && (aw_word == '0) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];

    always_comb begin
        sync_min_d = sync_min_q;
        if (aw_hs && (32'(aw_word) == 32'd3)) begin
            for (int b = 0; b < CNT_W; b++) begin
                if (S_AXI_WSTRB[b/8]) begin
                    sync_min_d[b] = S_AXI_WDATA[b];
                end
            end
        end
    end

    // a same-cycle commit or error overrides a software clear
    always_comb begin
        frame_valid_d = frame_valid_q;
        frame_err_d   = frame_err_q;
        if (clr_status) begin
            frame_valid_d = 1'b0;
            frame_err_d   = 1'b0;
        end
        if (commit) begin
            frame_valid_d = 1'b1;
        end
        if (frame_bad) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_en_q     <= 1'b0;
            ctrl_irq_q    <= 1'b0;
            sync_min_q    <= SYNC_RST;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            chans_q       <= '0;
            frame_cnt_q   <= '0;
        end else begin
            if (aw_hs && (aw_word == '0) && S_AXI_WSTRB[0]) begin
                ctrl_en_q  <= S_AXI_WDATA[0];
                ctrl_irq_q <= S_AXI_WDATA[2];
            end
            sync_min_q    <= sync_min_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            if (chans_we) begin
                chans_q <= 8'(ch_idx_q);
            end
            if (commit) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OK;
        if (!ar_ok) begin
            rd_resp = RESP_ERR;
        end else begin
            case (32'(ar_word))
                32'd0: rd_data = {29'd0, ctrl_irq_q, 1'b0, ctrl_en_q};
                32'd1: rd_data = {16'd0, chans_q, 6'd0, frame_err_q, frame_valid_q};
                32'd2: rd_data = frame_cnt_q;
                32'd3: rd_data[CNT_W-1:0] = sync_min_q;
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (32'(ar_word) == 32'(4 + i)) begin
                            rd_data[CNT_W-1:0] = ch_q[i];
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- AXI response channels ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdy_en_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OK;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OK;
            rdata_q  <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (aw_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= aw_ok ? RESP_OK : RESP_ERR;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_resp;
                rdata_q  <= rd_data;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = aw_hs;
    assign S_AXI_WREADY  = aw_hs;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ar_hs;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign IRQ           = frame_valid_q & ctrl_irq_q;

endmodule
